// File: rtl/stack_pkg.sv
// Shared types and constants for the stack push unit: request kinds, status-bit
// positions, frame size and the FSM state encoding.
package stack_pkg;

  localparam logic [7:0] STACK_PAGE_DEF = 8'h01;
  localparam int         MAX_FRAME      = 3;
  localparam int         P_BIT_B        = 4;
  localparam int         P_BIT_U        = 5;

  typedef enum logic [2:0] {
    KIND_A   = 3'd0,
    KIND_X   = 3'd1,
    KIND_Y   = 3'd2,
    KIND_P   = 3'd3,
    KIND_JSR = 3'd4,
    KIND_INT = 3'd5
  } req_kind_e;

  typedef logic [MAX_FRAME-1:0][7:0] frame_bytes_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PUSH   = 2'd1,
    ST_FINISH = 2'd2
  } push_state_e;

  // Status byte as it lands on the stack: U always set, B reflects the source.
  function automatic logic [7:0] pushed_status(input logic [7:0] p, input logic brk);
    logic [7:0] r;
    r          = p;
    r[P_BIT_U] = 1'b1;
    r[P_BIT_B] = brk;
    return r;
  endfunction

endpackage

// File: rtl/stack_push_unit_if.sv
// Request handshake and stack-write bus of the push unit. slave is the unit's view;
// master is the environment (CPU control plus memory) view.
interface stack_push_unit_if #(
  parameter int ADDR_W = 16
) ();

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_kind;
  logic              req_brk;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;
  logic              mem_ack;

  modport master (
    output req_valid, req_kind, req_brk, mem_ack,
    input  req_ready, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  req_valid, req_kind, req_brk, mem_ack,
    output req_ready, mem_addr, mem_data, mem_we
  );

endinterface

// File: rtl/stack_frame_builder.sv
// Combinational frame builder: maps a request kind and the register/PC values to
// the ordered list of bytes to push and how many of them are valid.
module stack_frame_builder
  import stack_pkg::*;
(
  input  logic [2:0]   kind,
  input  logic         brk,
  input  logic [7:0]   reg_a,
  input  logic [7:0]   reg_x,
  input  logic [7:0]   reg_y,
  input  logic [7:0]   reg_p,
  input  logic [15:0]  pc,
  output frame_bytes_t frame_bytes,
  output logic [1:0]   frame_count
);

  always_comb begin
    frame_bytes = '0;
    frame_count = 2'd0;
    case (req_kind_e'(kind))
      KIND_A: begin
        frame_bytes[0] = reg_a;
        frame_count    = 2'd1;
      end
      KIND_X: begin
        frame_bytes[0] = reg_x;
        frame_count    = 2'd1;
      end
      KIND_Y: begin
        frame_bytes[0] = reg_y;
        frame_count    = 2'd1;
      end
      KIND_P: begin
        frame_bytes[0] = pushed_status(reg_p, 1'b1);
        frame_count    = 2'd1;
      end
      KIND_JSR: begin
        frame_bytes[0] = pc[15:8];
        frame_bytes[1] = pc[7:0];
        frame_count    = 2'd2;
      end
      KIND_INT: begin
        frame_bytes[0] = pc[15:8];
        frame_bytes[1] = pc[7:0];
        frame_bytes[2] = pushed_status(reg_p, brk);
        frame_count    = 2'd3;
      end
      default: begin
        // Reserved kinds produce an empty frame.
        frame_count = 2'd0;
      end
    endcase
  end

endmodule

// File: rtl/stack_push_unit.sv
// Pushes 1-3 byte frames (PHA/PHX/PHY/PHP, JSR, interrupt) onto the stack page and
// hands the final SP back via sp_con. Optional STACK_WRAP_DETECT_EN adds a sticky wrap flag.
module stack_push_unit
  import stack_pkg::*;
#(
  parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEF,
  parameter int         ADDR_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  stack_push_unit_if.slave   bus,
  input  logic [7:0]         data_in_accumulator,
  input  logic [7:0]         data_in_x,
  input  logic [7:0]         data_in_y,
  input  logic [7:0]         data_in_status,
  input  logic [7:0]         data_in_sp,
  input  logic [15:0]        pc,
  output logic [7:0]         sp_out,
  output logic               sp_con,
  output logic               done,
  output logic               stack_wrap
);

  push_state_e  state_q, state_d;
  logic [7:0]   sp_q, sp_d;
  logic [1:0]   idx_q, idx_d;
  logic [1:0]   count_q, count_d;
  frame_bytes_t bytes_q, bytes_d;

  frame_bytes_t fb_bytes;
  logic [1:0]   fb_count;
  logic [7:0]   cur_byte;
  logic [15:0]  page_addr;
  logic         push_acked;

  stack_frame_builder u_builder (
    .kind        (bus.req_kind),
    .brk         (bus.req_brk),
    .reg_a       (data_in_accumulator),
    .reg_x       (data_in_x),
    .reg_y       (data_in_y),
    .reg_p       (data_in_status),
    .pc          (pc),
    .frame_bytes (fb_bytes),
    .frame_count (fb_count)
  );

  always_comb begin
    case (idx_q)
      2'd1:    cur_byte = bytes_q[1];
      2'd2:    cur_byte = bytes_q[2];
      default: cur_byte = bytes_q[0];
    endcase
  end

  assign push_acked = (state_q == ST_PUSH) && bus.mem_ack;

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    idx_d   = idx_q;
    count_d = count_q;
    bytes_d = bytes_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          bytes_d = fb_bytes;
          count_d = fb_count;
          sp_d    = data_in_sp;
          idx_d   = 2'd0;
          state_d = (fb_count == 2'd0) ? ST_FINISH : ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (bus.mem_ack) begin
          sp_d = sp_q - 8'd1;
          if (idx_q == count_q - 2'd1) begin
            state_d = ST_FINISH;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sp_q    <= 8'h00;
      idx_q   <= 2'd0;
      count_q <= 2'd0;
      bytes_q <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      bytes_q <= bytes_d;
    end
  end

  // Address and data come straight from registers, so they hold steady while mem_ack is low.
  assign page_addr     = {STACK_PAGE, sp_q};
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.mem_we    = (state_q == ST_PUSH);
  assign bus.mem_addr  = (state_q == ST_PUSH) ? ADDR_W'(page_addr) : '0;
  assign bus.mem_data  = (state_q == ST_PUSH) ? cur_byte : 8'h00;
  assign sp_con        = (state_q == ST_FINISH);
  assign done          = (state_q == ST_FINISH);
  assign sp_out        = sp_q;

`ifdef STACK_WRAP_DETECT_EN
  logic wrap_q, wrap_d;

  always_comb begin
    wrap_d = wrap_q;
    if (push_acked && (sp_q == 8'h00)) begin
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign stack_wrap = wrap_q;
`else
  logic unused_ack;
  assign unused_ack = push_acked;
  assign stack_wrap = 1'b0;
`endif

endmodule
